// File: rtl/pid_alu.sv
// Shared PID datapath ALU: operand select, scaled add/sub with 12-bit saturation,
// or Q12 signed multiply saturated to 15 bits. Define ALU_SAT_FLAG_EN to add sat_flag.
module pid_alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Accum,
  input  logic [15:0] Pcomp,
  input  logic [13:0] Pterm,
  input  logic [11:0] Fwd,
  input  logic [11:0] A2D_res,
  input  logic [11:0] Error,
  input  logic [11:0] Intgrl,
  input  logic [11:0] Icomp,
  input  logic [11:0] Iterm,
  input  logic [2:0]  src0sel,
  input  logic [2:0]  src1sel,
  input  logic        multiply,
  input  logic        sub,
  input  logic        mult2,
  input  logic        mult4,
  input  logic        saturate,
  output logic [15:0] dst
`ifdef ALU_SAT_FLAG_EN
  ,
  output logic        sat_flag
`endif
);

  logic [15:0]        src0, src1, s0, sum, add_res, mul_res, result;
  logic               add_hi, add_lo, mul_hi, mul_lo;
  logic signed [14:0] mul_a, mul_b;
  logic signed [29:0] prod, prod_q12;

  always_comb begin
    src0 = '0;
    case (src0sel)
      3'd0:    src0 = {4'b0000, A2D_res};
      3'd1:    src0 = {{4{Intgrl[11]}}, Intgrl};
      3'd2:    src0 = {{4{Icomp[11]}}, Icomp};
      3'd3:    src0 = Pcomp;
      3'd4:    src0 = {2'b00, Pterm};
      default: src0 = '0;
    endcase
  end

  always_comb begin
    src1 = '0;
    case (src1sel)
      3'd0:    src1 = Accum;
      3'd1:    src1 = {4'b0000, Iterm};
      3'd2:    src1 = {{4{Error[11]}}, Error};
      3'd3:    src1 = {{8{Error[11]}}, Error[11:4]};
      3'd4:    src1 = {4'b0000, Fwd};
      default: src1 = '0;
    endcase
  end

  always_comb begin
    s0 = src0;
    if (mult4)
      s0 = {src0[13:0], 2'b00};
    else if (mult2)
      s0 = {src0[14:0], 1'b0};
    sum    = src1 + (sub ? (~s0 + 16'd1) : s0);
    add_hi = saturate && ($signed(sum) > $signed(16'h07FF));
    add_lo = saturate && ($signed(sum) < $signed(16'hF800));
    if (add_hi)
      add_res = 16'h07FF;
    else if (add_lo)
      add_res = 16'hF800;
    else
      add_res = sum;
  end

  // Arithmetic shift of the full product keeps floor rounding and uses every product bit.
  always_comb begin
    mul_a    = $signed(src0[14:0]);
    mul_b    = $signed(src1[14:0]);
    prod     = mul_a * mul_b;
    prod_q12 = prod >>> 12;
    mul_hi   = prod_q12 > 30'sd16383;
    mul_lo   = prod_q12 < -30'sd16384;
    if (mul_hi)
      mul_res = 16'h3FFF;
    else if (mul_lo)
      mul_res = 16'hC000;
    else
      mul_res = prod_q12[15:0];
  end

  assign result = multiply ? mul_res : add_res;

  always_ff @(posedge clk) begin
    if (rst)
      dst <= '0;
    else
      dst <= result;
  end

`ifdef ALU_SAT_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst)
      sat_flag <= 1'b0;
    else
      sat_flag <= multiply ? (mul_hi | mul_lo) : (add_hi | add_lo);
  end
`endif

endmodule

// File: tb/tb_pid_alu.sv
// Scoreboard bench for pid_alu: directed ops push expected results; a monitor
// compares dst (and sat_flag when ALU_SAT_FLAG_EN is defined) one edge later.
module tb_pid_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Accum, Pcomp;
  logic [13:0] Pterm;
  logic [11:0] Fwd, A2D_res, Error, Intgrl, Icomp, Iterm;
  logic [2:0]  src0sel, src1sel;
  logic        multiply, sub, mult2, mult4, saturate;
  logic [15:0] dst;
`ifdef ALU_SAT_FLAG_EN
  logic        sat_flag;
`endif

  logic        op_valid = 1'b0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    string       name;
    logic [15:0] dst;
    logic        sat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  pid_alu dut (
    .clk(clk), .rst(rst), .Accum(Accum), .Pcomp(Pcomp), .Pterm(Pterm),
    .Fwd(Fwd), .A2D_res(A2D_res), .Error(Error), .Intgrl(Intgrl),
    .Icomp(Icomp), .Iterm(Iterm), .src0sel(src0sel), .src1sel(src1sel),
    .multiply(multiply), .sub(sub), .mult2(mult2), .mult4(mult4),
    .saturate(saturate), .dst(dst)
`ifdef ALU_SAT_FLAG_EN
    , .sat_flag(sat_flag)
`endif
  );

  // Monitor: an op applied before an edge must show up right after that edge.
  always @(posedge clk) begin
    logic v;
    exp_t e;
    v = op_valid;
    #1;
    if (v) begin
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: output with no expectation");
      end else begin
        e = sb.pop_front();
        checks++;
        if (dst !== e.dst) begin
          errors++;
          $display("FAIL %s: dst=0x%04h expected 0x%04h", e.name, dst, e.dst);
        end
`ifdef ALU_SAT_FLAG_EN
        checks++;
        if (sat_flag !== e.sat) begin
          errors++;
          $display("FAIL %s_sat: sat_flag=%0b expected %0b", e.name, sat_flag, e.sat);
        end
`endif
      end
    end
  end

  task automatic clear_ops();
    Accum = '0; Pcomp = '0; Pterm = '0; Fwd = '0; A2D_res = '0;
    Error = '0; Intgrl = '0; Icomp = '0; Iterm = '0;
  endtask

  // Called right after a negedge with operands already set.
  task automatic op(input string name, input logic [2:0] s0, input logic [2:0] s1,
                    input logic mul, input logic sb_, input logic m2, input logic m4,
                    input logic sat, input logic [15:0] exp_d, input logic exp_s);
    exp_t e;
    src0sel = s0; src1sel = s1; multiply = mul; sub = sb_;
    mult2 = m2; mult4 = m4; saturate = sat;
    op_valid = 1'b1;
    e.name = name; e.dst = exp_d; e.sat = exp_s;
    sb.push_back(e);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    clear_ops();
    src0sel = '0; src1sel = '0;
    multiply = 0; sub = 0; mult2 = 0; mult4 = 0; saturate = 0;
    @(negedge clk);
    Accum = 16'h1234; A2D_res = 12'h111;
    op("reset_state", 3'd0, 3'd0, 0, 0, 0, 0, 0, 16'h0000, 1'b0);
    @(negedge clk); rst = 1'b0;
    clear_ops(); Accum = 16'h0100; A2D_res = 12'h010;
    op("add", 3'd0, 3'd0, 0, 0, 0, 0, 0, 16'h0110, 1'b0);
    @(negedge clk);
    op("add_x2", 3'd0, 3'd0, 0, 0, 1, 0, 0, 16'h0120, 1'b0);
    @(negedge clk);
    op("sub_x4", 3'd0, 3'd0, 0, 1, 0, 1, 0, 16'h00C0, 1'b0);
    @(negedge clk);
    op("sub_x4_prio", 3'd0, 3'd0, 0, 1, 1, 1, 0, 16'h00C0, 1'b0);
    @(negedge clk); clear_ops(); A2D_res = 12'h001;
    op("sub_wrap", 3'd0, 3'd0, 0, 1, 0, 0, 0, 16'hFFFF, 1'b0);
    @(negedge clk); clear_ops(); Accum = 16'h07F0; A2D_res = 12'h020;
    op("sat_pos", 3'd0, 3'd0, 0, 0, 0, 0, 1, 16'h07FF, 1'b1);
    @(negedge clk); clear_ops(); Accum = 16'hF810; A2D_res = 12'h020;
    op("sat_neg", 3'd0, 3'd0, 0, 1, 0, 0, 1, 16'hF800, 1'b1);
    @(negedge clk);
    op("nosat_neg", 3'd0, 3'd0, 0, 1, 0, 0, 0, 16'hF7F0, 1'b0);
    @(negedge clk); clear_ops(); Accum = 16'h07FF;
    op("sat_edge", 3'd0, 3'd0, 0, 0, 0, 0, 1, 16'h07FF, 1'b0);
    @(negedge clk); clear_ops(); Pterm = 14'h3000; Error = 12'h7FF;
    op("mul_pos", 3'd4, 3'd2, 1, 1, 1, 1, 1, 16'h17FD, 1'b0);
    @(negedge clk); clear_ops(); Pterm = 14'h3FFF; Error = 12'h800;
    op("mul_neg", 3'd4, 3'd2, 1, 0, 0, 0, 0, 16'hE000, 1'b0);
    @(negedge clk); clear_ops(); Intgrl = 12'h800; Iterm = 12'h100;
    op("mul_int", 3'd1, 3'd1, 1, 0, 0, 0, 0, 16'hFF80, 1'b0);
    @(negedge clk); clear_ops(); Pcomp = 16'h3FFF; Accum = 16'h3FFF;
    op("mul_sat_pos", 3'd3, 3'd0, 1, 0, 0, 0, 0, 16'h3FFF, 1'b1);
    @(negedge clk); Pcomp = 16'h4000;
    op("mul_sat_neg", 3'd3, 3'd0, 1, 0, 0, 0, 0, 16'hC000, 1'b1);
    @(negedge clk); clear_ops(); Icomp = 12'hFFE; Fwd = 12'h100;
    op("icomp_fwd", 3'd2, 3'd4, 0, 0, 0, 0, 0, 16'h00FE, 1'b0);
    @(negedge clk); clear_ops(); Accum = 16'h0100; A2D_res = 12'h010;
    op("pre_reset", 3'd0, 3'd0, 0, 0, 0, 0, 0, 16'h0110, 1'b0);
    @(negedge clk); rst = 1'b1;
    op("mid_reset", 3'd0, 3'd0, 0, 0, 0, 0, 0, 16'h0000, 1'b0);
    @(negedge clk); rst = 1'b0; clear_ops(); Error = 12'h8F0;
    op("err_scaled", 3'd5, 3'd3, 0, 0, 0, 0, 0, 16'hFF8F, 1'b0);
    @(negedge clk); clear_ops(); Accum = 16'h5555; Pcomp = 16'h1111;
    op("unused_sel", 3'd7, 3'd6, 0, 0, 0, 0, 0, 16'h0000, 1'b0);
    @(negedge clk);
    op_valid = 1'b0;
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
